// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - main control FSM for the multi-cycle RV64I core
module multicycle_control_fsm #(
  parameter int INSTR_WIDTH   = 32,
  parameter int CONTROL_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     i_rst,
  input  logic [INSTR_WIDTH-1:0]   i_instr,
  input  logic                     i_mem_done,
  input  logic                     i_zero_flag,
  input  logic                     i_slt_flag,
  input  logic                     i_sltu_flag,
  output logic [CONTROL_WIDTH-1:0] o_alu_control,
  output logic [1:0]               o_src_1_sel,
  output logic [1:0]               o_src_2_sel,
  output logic [1:0]               o_result_sel,
  output logic                     o_pc_write,
  output logic                     o_instr_write,
  output logic                     o_reg_write,
  output logic                     o_mem_req,
  output logic                     o_mem_we,
  output logic                     o_illegal
);

  localparam logic [CONTROL_WIDTH-1:0] ALU_ADD   = CONTROL_WIDTH'(0);
  localparam logic [CONTROL_WIDTH-1:0] ALU_SUB   = CONTROL_WIDTH'(1);
  localparam logic [CONTROL_WIDTH-1:0] ALU_AND   = CONTROL_WIDTH'(2);
  localparam logic [CONTROL_WIDTH-1:0] ALU_OR    = CONTROL_WIDTH'(3);
  localparam logic [CONTROL_WIDTH-1:0] ALU_XOR   = CONTROL_WIDTH'(4);
  localparam logic [CONTROL_WIDTH-1:0] ALU_SLL   = CONTROL_WIDTH'(5);
  localparam logic [CONTROL_WIDTH-1:0] ALU_SLT   = CONTROL_WIDTH'(6);
  localparam logic [CONTROL_WIDTH-1:0] ALU_SLTU  = CONTROL_WIDTH'(7);
  localparam logic [CONTROL_WIDTH-1:0] ALU_SRL   = CONTROL_WIDTH'(8);
  localparam logic [CONTROL_WIDTH-1:0] ALU_SRA   = CONTROL_WIDTH'(9);
  localparam logic [CONTROL_WIDTH-1:0] ALU_ADDW  = CONTROL_WIDTH'(10);
  localparam logic [CONTROL_WIDTH-1:0] ALU_SUBW  = CONTROL_WIDTH'(11);
  localparam logic [CONTROL_WIDTH-1:0] ALU_SLLW  = CONTROL_WIDTH'(12);
  localparam logic [CONTROL_WIDTH-1:0] ALU_SRLW  = CONTROL_WIDTH'(13);
  localparam logic [CONTROL_WIDTH-1:0] ALU_SRAW  = CONTROL_WIDTH'(14);
  localparam logic [CONTROL_WIDTH-1:0] ALU_ADDIW = CONTROL_WIDTH'(15);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_RW    = 7'b0111011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_IW    = 7'b0011011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADDR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXEC_R, S_EXEC_I, S_ALU_WB, S_BRANCH, S_JAL, S_JAL_PC, S_LUI, S_FAULT
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic [5:0] w_funct6;
  logic       w_f7_zero;
  logic       w_f7_alt;
  logic       w_unused;

  assign w_opcode  = i_instr[6:0];
  assign w_funct3  = i_instr[14:12];
  assign w_funct7  = i_instr[31:25];
  assign w_funct6  = i_instr[31:26];
  assign w_f7_zero = (w_funct7 == 7'b0000000);
  assign w_f7_alt  = (w_funct7 == 7'b0100000);
  assign w_unused  = ^i_instr;

  logic [CONTROL_WIDTH-1:0] w_r_code;
  logic                     w_r_legal;

  always_comb begin
    w_r_code  = ALU_ADD;
    w_r_legal = 1'b0;
    if (w_opcode == OP_R) begin
      w_r_legal = w_f7_zero || (w_f7_alt && (w_funct3 == 3'b000 || w_funct3 == 3'b101));
      case (w_funct3)
        3'b000:  w_r_code = w_funct7[5] ? ALU_SUB : ALU_ADD;
        3'b001:  w_r_code = ALU_SLL;
        3'b010:  w_r_code = ALU_SLT;
        3'b011:  w_r_code = ALU_SLTU;
        3'b100:  w_r_code = ALU_XOR;
        3'b101:  w_r_code = w_funct7[5] ? ALU_SRA : ALU_SRL;
        3'b110:  w_r_code = ALU_OR;
        default: w_r_code = ALU_AND;
      endcase
    end else begin
      case (w_funct3)
        3'b000: begin
          w_r_legal = w_f7_zero || w_f7_alt;
          w_r_code  = w_funct7[5] ? ALU_SUBW : ALU_ADDW;
        end
        3'b001: begin
          w_r_legal = w_f7_zero;
          w_r_code  = ALU_SLLW;
        end
        3'b101: begin
          w_r_legal = w_f7_zero || w_f7_alt;
          w_r_code  = w_funct7[5] ? ALU_SRAW : ALU_SRLW;
        end
        default: w_r_legal = 1'b0;
      endcase
    end
  end

  // RV64 immediate shifts carry a 6-bit shamt, so only funct6 qualifies them
  logic [CONTROL_WIDTH-1:0] w_i_code;
  logic                     w_i_legal;

  always_comb begin
    w_i_code  = ALU_ADD;
    w_i_legal = 1'b1;
    if (w_opcode == OP_I) begin
      case (w_funct3)
        3'b000:  w_i_code = ALU_ADD;
        3'b001: begin
          w_i_code  = ALU_SLL;
          w_i_legal = (w_funct6 == 6'b000000);
        end
        3'b010:  w_i_code = ALU_SLT;
        3'b011:  w_i_code = ALU_SLTU;
        3'b100:  w_i_code = ALU_XOR;
        3'b101: begin
          w_i_code  = i_instr[30] ? ALU_SRA : ALU_SRL;
          w_i_legal = (w_funct6 == 6'b000000) || (w_funct6 == 6'b010000);
        end
        3'b110:  w_i_code = ALU_OR;
        default: w_i_code = ALU_AND;
      endcase
    end else begin
      case (w_funct3)
        3'b000:  w_i_code = ALU_ADDIW;
        3'b001: begin
          w_i_code  = ALU_SLLW;
          w_i_legal = w_f7_zero;
        end
        3'b101: begin
          w_i_code  = w_funct7[5] ? ALU_SRAW : ALU_SRLW;
          w_i_legal = w_f7_zero || w_f7_alt;
        end
        default: w_i_legal = 1'b0;
      endcase
    end
  end

  logic [CONTROL_WIDTH-1:0] w_br_code;
  logic                     w_br_taken;
  logic                     w_br_legal;

  always_comb begin
    w_br_code  = ALU_ADD;
    w_br_taken = 1'b0;
    w_br_legal = 1'b1;
    case (w_funct3)
      3'b000: begin w_br_code = ALU_SUB;  w_br_taken = i_zero_flag;  end
      3'b001: begin w_br_code = ALU_SUB;  w_br_taken = !i_zero_flag; end
      3'b100: begin w_br_code = ALU_SLT;  w_br_taken = i_slt_flag;   end
      3'b101: begin w_br_code = ALU_SLT;  w_br_taken = !i_slt_flag;  end
      3'b110: begin w_br_code = ALU_SLTU; w_br_taken = i_sltu_flag;  end
      3'b111: begin w_br_code = ALU_SLTU; w_br_taken = !i_sltu_flag; end
      default: w_br_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    o_alu_control = ALU_ADD;
    o_src_1_sel   = 2'd0;
    o_src_2_sel   = 2'd0;
    o_result_sel  = 2'd0;
    o_pc_write    = 1'b0;
    o_instr_write = 1'b0;
    o_reg_write   = 1'b0;
    o_mem_req     = 1'b0;
    o_mem_we      = 1'b0;
    o_illegal     = 1'b0;
    case (r_state)
      S_FETCH: begin
        o_src_2_sel  = 2'd2;
        o_result_sel = 2'd2;
        o_mem_req    = 1'b1;
        if (i_mem_done) begin
          o_instr_write = 1'b1;
          o_pc_write    = 1'b1;
          w_state_next  = S_DECODE;
        end
      end
      S_DECODE: begin
        o_src_1_sel = 2'd1;
        o_src_2_sel = 2'd1;
        case (w_opcode)
          OP_LOAD, OP_STORE: w_state_next = S_MEMADDR;
          OP_R, OP_RW:       w_state_next = S_EXEC_R;
          OP_I, OP_IW:       w_state_next = S_EXEC_I;
          OP_BR:             w_state_next = S_BRANCH;
          OP_JAL:            w_state_next = S_JAL;
          OP_LUI:            w_state_next = S_LUI;
          default:           w_state_next = S_FAULT;
        endcase
      end
      S_MEMADDR: begin
        o_src_1_sel  = 2'd2;
        o_src_2_sel  = 2'd1;
        w_state_next = (w_opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        o_mem_req = 1'b1;
        if (i_mem_done) w_state_next = S_MEMWB;
      end
      S_MEMWB: begin
        o_result_sel = 2'd1;
        o_reg_write  = 1'b1;
        w_state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        o_mem_req = 1'b1;
        o_mem_we  = 1'b1;
        if (i_mem_done) w_state_next = S_FETCH;
      end
      S_EXEC_R: begin
        o_alu_control = w_r_code;
        o_src_1_sel   = 2'd2;
        w_state_next  = w_r_legal ? S_ALU_WB : S_FAULT;
      end
      S_EXEC_I: begin
        o_alu_control = w_i_code;
        o_src_1_sel   = 2'd2;
        o_src_2_sel   = 2'd1;
        w_state_next  = w_i_legal ? S_ALU_WB : S_FAULT;
      end
      S_ALU_WB: begin
        o_reg_write  = 1'b1;
        w_state_next = S_FETCH;
      end
      S_BRANCH: begin
        o_alu_control = w_br_code;
        o_src_1_sel   = 2'd2;
        o_pc_write    = w_br_legal && w_br_taken;
        w_state_next  = w_br_legal ? S_FETCH : S_FAULT;
      end
      S_JAL: begin
        o_src_1_sel  = 2'd1;
        o_src_2_sel  = 2'd2;
        o_result_sel = 2'd2;
        o_reg_write  = 1'b1;
        w_state_next = S_JAL_PC;
      end
      S_JAL_PC: begin
        o_pc_write   = 1'b1;
        w_state_next = S_FETCH;
      end
      S_LUI: begin
        // select 3 makes the datapath feed zero, so OR passes the immediate
        o_alu_control = ALU_OR;
        o_src_1_sel   = 2'd3;
        o_src_2_sel   = 2'd1;
        o_result_sel  = 2'd2;
        o_reg_write   = 1'b1;
        w_state_next  = S_FETCH;
      end
      S_FAULT: begin
        o_illegal = 1'b1;
      end
      default: w_state_next = S_FETCH;
    endcase
    if (i_rst) begin
      w_state_next  = S_FETCH;
      o_alu_control = ALU_ADD;
      o_src_1_sel   = 2'd0;
      o_src_2_sel   = 2'd0;
      o_result_sel  = 2'd0;
      o_pc_write    = 1'b0;
      o_instr_write = 1'b0;
      o_reg_write   = 1'b0;
      o_mem_req     = 1'b0;
      o_mem_we      = 1'b0;
      o_illegal     = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - randomized self-checking bench for multicycle_control_fsm
module tb_multicycle_control_fsm;

  localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4, K_JAL = 5, K_LUI = 6,
                 K_ILLOP = 7, K_ILLEX = 8;

  typedef struct {
    logic [31:0] tmpl;
    logic [31:0] mask;
    int kind;
    int code;
    int cond;
  } ent_t;

  typedef struct {
    int alu, s1, s2, rs, pcw, iw, rw, req, we, ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_instr;
  logic        i_mem_done;
  logic        i_zero_flag;
  logic        i_slt_flag;
  logic        i_sltu_flag;
  logic [4:0]  o_alu_control;
  logic [1:0]  o_src_1_sel;
  logic [1:0]  o_src_2_sel;
  logic [1:0]  o_result_sel;
  logic        o_pc_write;
  logic        o_instr_write;
  logic        o_reg_write;
  logic        o_mem_req;
  logic        o_mem_we;
  logic        o_illegal;

  int checks = 0;
  int failures = 0;
  ent_t tab[$];

  always #5 clk = ~clk;

  multicycle_control_fsm #(.INSTR_WIDTH(32), .CONTROL_WIDTH(5)) dut (
    .clk(clk), .i_rst(i_rst), .i_instr(i_instr), .i_mem_done(i_mem_done),
    .i_zero_flag(i_zero_flag), .i_slt_flag(i_slt_flag), .i_sltu_flag(i_sltu_flag),
    .o_alu_control(o_alu_control), .o_src_1_sel(o_src_1_sel), .o_src_2_sel(o_src_2_sel),
    .o_result_sel(o_result_sel), .o_pc_write(o_pc_write), .o_instr_write(o_instr_write),
    .o_reg_write(o_reg_write), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
    .o_illegal(o_illegal)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t base();
    exp_t e;
    e.alu = -1; e.s1 = -1; e.s2 = -1; e.rs = -1;
    e.pcw = 0; e.iw = 0; e.rw = 0; e.req = 0; e.we = 0; e.ill = 0;
    return e;
  endfunction

  function automatic exp_t rst_exp();
    exp_t e;
    e = base();
    e.alu = 0; e.s1 = 0; e.s2 = 0; e.rs = 0;
    return e;
  endfunction

  function automatic ent_t mk(input logic [31:0] tmpl, input logic [31:0] mask,
                              input int kind, input int code, input int cond);
    ent_t t;
    t.tmpl = tmpl; t.mask = mask; t.kind = kind; t.code = code; t.cond = cond;
    return t;
  endfunction

  task automatic cyc(input string tag, input exp_t e, input logic [31:0] ins,
                     input logic done, input logic [2:0] fl, input logic rst);
    @(negedge clk);
    i_rst = rst;
    i_instr = ins;
    i_mem_done = done;
    {i_zero_flag, i_slt_flag, i_sltu_flag} = fl;
    #1;
    if (e.alu >= 0) check_eq({tag, ".alu"}, 32'(o_alu_control), e.alu);
    if (e.s1 >= 0)  check_eq({tag, ".src_1"}, 32'(o_src_1_sel), e.s1);
    if (e.s2 >= 0)  check_eq({tag, ".src_2"}, 32'(o_src_2_sel), e.s2);
    if (e.rs >= 0)  check_eq({tag, ".result_sel"}, 32'(o_result_sel), e.rs);
    check_eq({tag, ".pc_write"}, 32'(o_pc_write), e.pcw);
    check_eq({tag, ".instr_write"}, 32'(o_instr_write), e.iw);
    check_eq({tag, ".reg_write"}, 32'(o_reg_write), e.rw);
    check_eq({tag, ".mem_req"}, 32'(o_mem_req), e.req);
    check_eq({tag, ".mem_we"}, 32'(o_mem_we), e.we);
    check_eq({tag, ".illegal"}, 32'(o_illegal), e.ill);
  endtask

  // Expected behaviour comes from the instruction class in the table entry,
  // one phase at a time, with memory waits stretched by fd/md cycles.
  task automatic run_instr(input ent_t t, input logic [31:0] ins, input int fd,
                           input int md, input int fl_force, input bit abort);
    exp_t e;
    logic [2:0] fl;
    bit taken;
    for (int k = 0; k <= fd; k++) begin
      e = base(); e.alu = 0; e.s1 = 0; e.s2 = 2; e.req = 1;
      if (k == fd) begin e.rs = 2; e.pcw = 1; e.iw = 1; end
      cyc("fetch", e, $urandom(), k == fd, 3'($urandom()), 1'b0);
    end
    e = base(); e.alu = 0; e.s1 = 1; e.s2 = 1;
    cyc("decode", e, ins, 1'($urandom()), 3'($urandom()), 1'b0);
    case (t.kind)
      K_R, K_I: begin
        e = base(); e.alu = t.code; e.s1 = 2; e.s2 = (t.kind == K_I) ? 1 : 0;
        cyc("exec", e, ins, 1'($urandom()), 3'($urandom()), 1'b0);
        e = base(); e.rs = 0; e.rw = 1;
        cyc("alu_wb", e, ins, 1'($urandom()), 3'($urandom()), 1'b0);
      end
      K_LD, K_ST: begin
        e = base(); e.alu = 0; e.s1 = 2; e.s2 = 1;
        cyc("memaddr", e, ins, 1'($urandom()), 3'($urandom()), 1'b0);
        if (abort) begin
          cyc("rst_in_mem", rst_exp(), ins, 1'b1, 3'($urandom()), 1'b1);
        end else begin
          for (int k = 0; k <= md; k++) begin
            e = base(); e.req = 1; e.we = (t.kind == K_ST) ? 1 : 0;
            cyc((t.kind == K_ST) ? "memwrite" : "memread", e, ins, k == md,
                3'($urandom()), 1'b0);
          end
          if (t.kind == K_LD) begin
            e = base(); e.rs = 1; e.rw = 1;
            cyc("memwb", e, ins, 1'($urandom()), 3'($urandom()), 1'b0);
          end
        end
      end
      K_BR: begin
        fl = (fl_force >= 0) ? 3'(fl_force) : 3'($urandom());
        case (t.cond)
          0: taken = fl[2];
          1: taken = !fl[2];
          2: taken = fl[1];
          3: taken = !fl[1];
          4: taken = fl[0];
          default: taken = !fl[0];
        endcase
        e = base(); e.alu = t.code; e.s1 = 2; e.s2 = 0; e.rs = 0; e.pcw = int'(taken);
        cyc("branch", e, ins, 1'($urandom()), fl, 1'b0);
      end
      K_JAL: begin
        e = base(); e.alu = 0; e.s1 = 1; e.s2 = 2; e.rs = 2; e.rw = 1;
        cyc("jal", e, ins, 1'($urandom()), 3'($urandom()), 1'b0);
        e = base(); e.rs = 0; e.pcw = 1;
        cyc("jal_pc", e, ins, 1'($urandom()), 3'($urandom()), 1'b0);
      end
      K_LUI: begin
        e = base(); e.alu = 3; e.s1 = 3; e.s2 = 1; e.rs = 2; e.rw = 1;
        cyc("lui", e, ins, 1'($urandom()), 3'($urandom()), 1'b0);
      end
      default: begin
        if (t.kind == K_ILLEX) begin
          e = base();
          cyc("exec_bad", e, ins, 1'($urandom()), 3'($urandom()), 1'b0);
        end
        for (int k = 0; k < 10; k++) begin
          e = base(); e.ill = 1;
          cyc("fault", e, $urandom(), 1'($urandom()), 3'($urandom()), 1'b0);
        end
        cyc("fault_rst", rst_exp(), ins, 1'($urandom()), 3'($urandom()), 1'b1);
      end
    endcase
  endtask

  initial begin
    ent_t t;
    logic [31:0] ins;
    int idx;

    i_rst = 1'b1; i_instr = '0; i_mem_done = 1'b0;
    i_zero_flag = 1'b0; i_slt_flag = 1'b0; i_sltu_flag = 1'b0;
    cyc("reset", rst_exp(), 32'h0, 1'b1, 3'b111, 1'b1);
    cyc("reset", rst_exp(), $urandom(), 1'b0, 3'b000, 1'b1);

    tab.push_back(mk(32'h00000033, 32'h01FF8F80, K_R, 0, 0));
    tab.push_back(mk(32'h40000033, 32'h01FF8F80, K_R, 1, 0));
    tab.push_back(mk(32'h00001033, 32'h01FF8F80, K_R, 5, 0));
    tab.push_back(mk(32'h00002033, 32'h01FF8F80, K_R, 6, 0));
    tab.push_back(mk(32'h00003033, 32'h01FF8F80, K_R, 7, 0));
    tab.push_back(mk(32'h00004033, 32'h01FF8F80, K_R, 4, 0));
    tab.push_back(mk(32'h00005033, 32'h01FF8F80, K_R, 8, 0));
    tab.push_back(mk(32'h40005033, 32'h01FF8F80, K_R, 9, 0));
    tab.push_back(mk(32'h00006033, 32'h01FF8F80, K_R, 3, 0));
    tab.push_back(mk(32'h00007033, 32'h01FF8F80, K_R, 2, 0));
    tab.push_back(mk(32'h0000003B, 32'h01FF8F80, K_R, 10, 0));
    tab.push_back(mk(32'h4000003B, 32'h01FF8F80, K_R, 11, 0));
    tab.push_back(mk(32'h0000103B, 32'h01FF8F80, K_R, 12, 0));
    tab.push_back(mk(32'h0000503B, 32'h01FF8F80, K_R, 13, 0));
    tab.push_back(mk(32'h4000503B, 32'h01FF8F80, K_R, 14, 0));
    tab.push_back(mk(32'h00000013, 32'hFFFF8F80, K_I, 0, 0));
    tab.push_back(mk(32'h00001013, 32'h03FF8F80, K_I, 5, 0));
    tab.push_back(mk(32'h00002013, 32'hFFFF8F80, K_I, 6, 0));
    tab.push_back(mk(32'h00003013, 32'hFFFF8F80, K_I, 7, 0));
    tab.push_back(mk(32'h00004013, 32'hFFFF8F80, K_I, 4, 0));
    tab.push_back(mk(32'h00005013, 32'h03FF8F80, K_I, 8, 0));
    tab.push_back(mk(32'h40005013, 32'h03FF8F80, K_I, 9, 0));
    tab.push_back(mk(32'h00006013, 32'hFFFF8F80, K_I, 3, 0));
    tab.push_back(mk(32'h00007013, 32'hFFFF8F80, K_I, 2, 0));
    tab.push_back(mk(32'h0000001B, 32'hFFFF8F80, K_I, 15, 0));
    tab.push_back(mk(32'h0000101B, 32'h01FF8F80, K_I, 12, 0));
    tab.push_back(mk(32'h0000501B, 32'h01FF8F80, K_I, 13, 0));
    tab.push_back(mk(32'h4000501B, 32'h01FF8F80, K_I, 14, 0));
    tab.push_back(mk(32'h00000003, 32'hFFFF8F80, K_LD, 0, 0));
    tab.push_back(mk(32'h00003003, 32'hFFFF8F80, K_LD, 0, 0));
    tab.push_back(mk(32'h00006003, 32'hFFFF8F80, K_LD, 0, 0));
    tab.push_back(mk(32'h00000023, 32'hFFFF8F80, K_ST, 0, 0));
    tab.push_back(mk(32'h00003023, 32'hFFFF8F80, K_ST, 0, 0));
    tab.push_back(mk(32'h00000063, 32'hFFFF8F80, K_BR, 1, 0));
    tab.push_back(mk(32'h00001063, 32'hFFFF8F80, K_BR, 1, 1));
    tab.push_back(mk(32'h00004063, 32'hFFFF8F80, K_BR, 6, 2));
    tab.push_back(mk(32'h00005063, 32'hFFFF8F80, K_BR, 6, 3));
    tab.push_back(mk(32'h00006063, 32'hFFFF8F80, K_BR, 7, 4));
    tab.push_back(mk(32'h00007063, 32'hFFFF8F80, K_BR, 7, 5));
    tab.push_back(mk(32'h0000006F, 32'hFFFFFF80, K_JAL, 0, 0));
    tab.push_back(mk(32'h00000037, 32'hFFFFFF80, K_LUI, 3, 0));
    tab.push_back(mk(32'h0000007F, 32'hFFFFFF80, K_ILLOP, 0, 0));
    tab.push_back(mk(32'h0000000F, 32'hFFFFFF80, K_ILLOP, 0, 0));
    tab.push_back(mk(32'h00000017, 32'hFFFFFF80, K_ILLOP, 0, 0));
    tab.push_back(mk(32'h02000033, 32'h01FF8F80, K_ILLEX, 0, 0));
    tab.push_back(mk(32'h0000203B, 32'h01FF8F80, K_ILLEX, 0, 0));
    tab.push_back(mk(32'h04001013, 32'h01FF8F80, K_ILLEX, 0, 0));
    tab.push_back(mk(32'h0000201B, 32'hFFFF8F80, K_ILLEX, 0, 0));

    run_instr(mk(0, 0, K_R, 0, 0), 32'h002081B3, 0, 0, -1, 1'b0);
    run_instr(mk(0, 0, K_R, 14, 0), 32'h4020D1BB, 0, 0, -1, 1'b0);
    run_instr(mk(0, 0, K_I, 15, 0), 32'h0010809B, 0, 0, -1, 1'b0);
    run_instr(mk(0, 0, K_BR, 1, 0), 32'h00208463, 0, 0, 4, 1'b0);
    run_instr(mk(0, 0, K_BR, 1, 0), 32'h00208463, 0, 0, 3, 1'b0);
    run_instr(mk(0, 0, K_LD, 0, 0), 32'h0000B283, 0, 3, -1, 1'b0);
    run_instr(mk(0, 0, K_ILLOP, 0, 0), 32'h0000007F, 0, 0, -1, 1'b0);
    run_instr(mk(0, 0, K_ST, 0, 0), 32'h00113023, 0, 0, -1, 1'b1);
    run_instr(mk(0, 0, K_JAL, 0, 0), 32'h008000EF, 2, 0, -1, 1'b0);
    run_instr(mk(0, 0, K_LUI, 3, 0), 32'h123452B7, 1, 0, -1, 1'b0);

    for (int n = 0; n < 250; n++) begin
      idx = $urandom_range(0, tab.size() - 1);
      t = tab[idx];
      ins = (t.tmpl & ~t.mask) | ($urandom() & t.mask);
      run_instr(t, ins, $urandom_range(0, 3), $urandom_range(0, 3), -1,
                (t.kind == K_ST) && ($urandom_range(0, 7) == 0));
    end
    run_instr(mk(0, 0, K_R, 0, 0), 32'h002081B3, 0, 0, -1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
